// File: rtl/patp_alu_pkg.sv
// Shared types and helpers for the PATP sequential ALU: op codes, FSM states,
// and the add/sub carry helper used by the single-cycle ops.
package patp_alu_pkg;

    typedef enum logic [2:0] {
        FN_CLR  = 3'b000,
        FN_INC  = 3'b001,
        FN_ADD  = 3'b010,
        FN_DEC  = 3'b011,
        FN_SUB  = 3'b100,
        FN_AND  = 3'b101,
        FN_PASS = 3'b110,
        FN_MUL  = 3'b111
    } alu_func_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // Operands arrive zero-extended to 32 bits; for add the carry is bit
    // 'width' of the sum, for subtract it is the borrow (b > a).
    function automatic logic addsub_carry(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input int unsigned width);
        logic [32:0] sum;
        logic [32:0] sh;
        sum = {1'b0, a} + {1'b0, b};
        sh  = sum >> width;
        if (sub) begin
            return (b > a);
        end
        return sh[0];
    endfunction

endpackage

// File: rtl/patp_mul_iter.sv
// Shift-add multiply datapath: one partial product per step, WIDTH steps.
// product_next_o is the accumulator value that the current step will write.
module patp_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   product_next_o,
    output logic                 last_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign product_next_o = acc_d;
    assign last_o         = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/patp_alu_seq.sv
// Registered PATP ALU with start/busy/done handshake and flag outputs.
// Define PATP_ALU_MUL_EN to build the multi-cycle shift-add multiply.
module patp_alu_seq
    import patp_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             neg
);

    alu_func_e        func_e;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             done_q;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             single_fire;

    assign func_e = alu_func_e'(func);

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        case (func_e)
            FN_CLR:  op_res = '0;
            FN_INC:  begin
                op_res   = q + WIDTH'(1);
                op_carry = addsub_carry(32'(q), 32'd1, 1'b0, WIDTH);
            end
            FN_ADD:  begin
                op_res   = q + p;
                op_carry = addsub_carry(32'(q), 32'(p), 1'b0, WIDTH);
            end
            FN_DEC:  begin
                op_res   = q - WIDTH'(1);
                op_carry = addsub_carry(32'(q), 32'd1, 1'b1, WIDTH);
            end
            FN_SUB:  begin
                op_res   = q - p;
                op_carry = addsub_carry(32'(q), 32'(p), 1'b1, WIDTH);
            end
            FN_AND:  op_res = q & p;
            FN_PASS: op_res = p;
            // Single-cycle MUL only exists without the multiplier: flag it unsupported.
            FN_MUL:  op_carry = 1'b1;
            default: op_res = '0;
        endcase
    end

`ifdef PATP_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_e         state_q;
    alu_state_e         state_d;
    logic               accept;
    logic               mul_last;
    logic               mul_fin;
    logic [2*WIDTH-1:0] prod_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && func_e == FN_MUL) state_d = ST_MUL;
            ST_MUL:  if (mul_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_MUL);
    end

    assign accept      = start && (state_q == ST_IDLE);
    assign single_fire = accept && (func_e != FN_MUL);
    assign mul_fin     = (state_q == ST_MUL) && mul_last;

    patp_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (accept && (func_e == FN_MUL)),
        .step_i         (state_q == ST_MUL),
        .mcand_i        (q),
        .mplier_i       (p),
        .product_next_o (prod_next),
        .last_o         (mul_last)
    );
`else
    assign busy        = 1'b0;
    assign single_fire = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (single_fire) begin
                result_q <= op_res;
                carry_q  <= op_carry;
                done_q   <= 1'b1;
            end
`ifdef PATP_ALU_MUL_EN
            else if (mul_fin) begin
                result_q <= prod_next[WIDTH-1:0];
                carry_q  <= |prod_next[2*WIDTH-1:WIDTH];
                done_q   <= 1'b1;
            end
`endif
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign done   = done_q;
    assign zero   = (result_q == '0);
    assign neg    = result_q[WIDTH-1];

endmodule
